// File: rtl/rand_sched_pkg.sv
// Shared definitions for the random-word grant scheduler: FSM encoding and
// default sizing constants.
package rand_sched_pkg;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    SEED       = 2'd1,
    COOL       = 2'd2,
    READY      = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_OUT_W       = 16;
  localparam int DEF_COOL_CYCLES = 16;

endpackage

// File: rtl/rand_scheduler_rr_picker.sv
// Combinational round-robin picker: one-hot select of the first set request
// at or above ptr, wrapping around to index 0.
module rr_picker
  import rand_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);

  localparam logic [PTR_W:0] N = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // One extra bit so ptr+i can exceed NUM_REQ-1 before the wrap.
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rand_scheduler.sv
// Hands out one fresh random word per grant to round-robin requesters, with a
// cooldown between grants so the LFSR shifts in new bits.
module rand_scheduler
  import rand_sched_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int COOL_CYCLES = DEF_COOL_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               reseed,
  input  logic [63:0]        rand_in,
  output logic               lfsr_load,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [OUT_W-1:0]   rand_out,
  output logic               ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOL_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] pick;

  generate
    if (OUT_W < 64) begin : g_unused
      logic unused_rand;
      assign unused_rand = ^rand_in[63:OUT_W];
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
    next_ptr = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_START;
      cnt       <= '0;
      ptr       <= '0;
      lfsr_load <= 1'b0;
      grant     <= '0;
      rand_out  <= '0;
      ready     <= 1'b0;
    end else begin
      // Strobes default low; only the transitions below raise them.
      lfsr_load <= 1'b0;
      grant     <= '0;
      case (state)
        WAIT_START: begin
          if (start) begin
            state     <= SEED;
            lfsr_load <= 1'b1;
          end
        end
        SEED: begin
          state <= COOL;
          cnt   <= CNT_LOAD;
        end
        COOL: begin
          if (reseed) begin
            state     <= SEED;
            lfsr_load <= 1'b1;
          end else if (cnt == '0) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READY: begin
          if (reseed) begin
            state     <= SEED;
            lfsr_load <= 1'b1;
            ready     <= 1'b0;
          end else if (|req) begin
            grant    <= pick;
            rand_out <= rand_in[OUT_W-1:0];
            ptr      <= next_ptr;
            cnt      <= CNT_LOAD;
            state    <= COOL;
            ready    <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_START;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_scheduler.sv
// Directed bench for rand_scheduler: table-driven round-robin grants plus
// hand-written startup, spacing, reseed, cooldown-drop and reset sequences.
module tb_rand_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        reseed = 1'b0;
  logic [63:0] rand_in = '0;
  logic        lfsr_load;
  logic [3:0]  req = '0;
  logic [3:0]  grant;
  logic [15:0] rand_out;
  logic        ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rand_scheduler #(
    .NUM_REQ     (4),
    .OUT_W       (16),
    .COOL_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reseed    (reseed),
    .rand_in   (rand_in),
    .lfsr_load (lfsr_load),
    .req       (req),
    .grant     (grant),
    .rand_out  (rand_out),
    .ready     (ready)
  );

  typedef struct {
    logic [3:0]  req;
    logic [63:0] rin;
    logic [3:0]  exp_grant;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk(name, 64'(ready), 64'd1);
  endtask

  initial begin
    logic [3:0]  seq [5];
    logic [63:0] rin_cur;
    int          n;
    int          last;
    int          bad;

    // ptr starts at 0; each entry's expectation follows from the previous grant.
    vecs[0] = '{4'b0100, 64'h0123_4567_89AB_CDEF, 4'b0100}; // ptr -> 3
    vecs[1] = '{4'b1111, 64'h1111_2222_3333_4444, 4'b1000}; // ptr -> 0
    vecs[2] = '{4'b0011, 64'hFFFF_0000_FFFF_0001, 4'b0001}; // ptr -> 1
    vecs[3] = '{4'b0011, 64'h0000_0000_0000_8000, 4'b0010}; // ptr -> 2
    vecs[4] = '{4'b0001, 64'hDEAD_BEEF_CAFE_F00D, 4'b0001}; // ptr -> 1
    vecs[5] = '{4'b1010, 64'h5555_AAAA_5555_AAAA, 4'b0010}; // ptr -> 2
    vecs[6] = '{4'b1010, 64'h0F0F_0F0F_0F0F_1234, 4'b1000}; // ptr -> 0
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Held in reset, with requests present that must be ignored.
    req = 4'b1111;
    repeat (3) tick();
    chk("reset_outputs", {43'd0, lfsr_load, grant, rand_out, ready}, 64'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("wait_start_no_grant", {grant, ready, lfsr_load}, 64'd0);
    req = 4'b0000;

    // Startup: seed strobe for one cycle, then 16 cooldown cycles before READY.
    start = 1'b1;
    tick();
    chk("seed_strobe", {lfsr_load, ready, grant}, {1'b1, 1'b0, 4'b0000});
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (lfsr_load !== 1'b0 || ready !== 1'b0 || grant !== 4'b0000) bad++;
    end
    chk("startup_cool_quiet", 64'(bad), 64'd0);
    tick();
    chk("startup_ready", 64'(ready), 64'd1);
    start = 1'b0;

    // Table-driven round-robin grants with captured random words.
    for (int i = 0; i < 7; i++) begin
      wait_ready($sformatf("vec%0d_ready", i));
      req = vecs[i].req;
      rand_in = vecs[i].rin;
      tick();
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_rand", i), 64'(rand_out), 64'(vecs[i].rin[15:0]));
      chk($sformatf("vec%0d_ready_low", i), 64'(ready), 64'd0);
      req = 4'b0000;
      rand_in = ~vecs[i].rin;
      tick();
      chk($sformatf("vec%0d_pulse", i), 64'(grant), 64'd0);
      chk($sformatf("vec%0d_hold", i), 64'(rand_out), 64'(vecs[i].rin[15:0]));
    end

    // Continuous requests: rotation and exact 17-cycle spacing.
    wait_ready("spacing_ready");
    req = 4'b1111;
    n = 0;
    last = 0;
    for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
      rin_cur = {32'hCAFE_0000 + 32'(cyc), 32'h1234_0000 + 32'(cyc * 7)};
      rand_in = rin_cur;
      tick();
      if (grant !== 4'b0000) begin
        chk($sformatf("rr_grant%0d", n), 64'(grant), 64'(seq[n]));
        chk($sformatf("rr_rand%0d", n), 64'(rand_out), 64'(rin_cur[15:0]));
        if (n == 0) chk("rr_first_latency", 64'(cyc), 64'd0);
        else chk($sformatf("rr_spacing%0d", n), 64'(cyc - last), 64'd17);
        last = cyc;
        n++;
      end
    end
    chk("rr_grant_count", 64'(n), 64'd5);
    req = 4'b0000;

    // Reseed in the same cycle as a request: no grant, reseed, full cooldown.
    wait_ready("reseed_ready");
    req = 4'b0001;
    reseed = 1'b1;
    tick();
    chk("reseed_edge", {grant, lfsr_load, ready}, {4'b0000, 1'b1, 1'b0});
    reseed = 1'b0;
    bad = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (grant !== 4'b0000 || lfsr_load !== 1'b0) bad++;
    end
    chk("reseed_cool_quiet", 64'(bad), 64'd0);
    tick();
    chk("reseed_then_grant", 64'(grant), 64'(4'b0001));
    req = 4'b0000;

    // Request raised and dropped during cooldown leaves no trace (ptr stays 1).
    tick();
    req = 4'b0010;
    tick();
    tick();
    tick();
    req = 4'b0000;
    wait_ready("drop_ready");
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (grant !== 4'b0000 || ready !== 1'b1) bad++;
    end
    chk("drop_no_grant", 64'(bad), 64'd0);
    req = 4'b0011;
    rand_in = 64'h0000_0000_0000_BEEF;
    tick();
    chk("drop_ptr_kept", 64'(grant), 64'(4'b0010));
    chk("drop_rand", 64'(rand_out), 64'h0000_BEEF);
    req = 4'b0000;

    // Reset during cooldown clears outputs immediately; no grant without start.
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {43'd0, lfsr_load, grant, rand_out, ready}, 64'd0);
    tick();
    rst = 1'b1;
    req = 4'b1111;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (grant !== 4'b0000 || lfsr_load !== 1'b0 || ready !== 1'b0) bad++;
    end
    chk("no_start_no_grant", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_scheduler.md
RAND_SCHEDULER -- requirements
Module: rand_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (obstacle, coin, missile, zapper spawners).
REQ-002 Parameter OUT_W, default 16, width of random word delivered per grant.
REQ-003 Parameter COOL_CYCLES, default 16, shift cycles between grants; SHALL be >= OUT_W so every delivered bit is fresh.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level, seeds generator once after reset (player's first button press).
REQ-007 reseed  in  1  level, forces a new seed (new game).
REQ-008 rand_in  in  64  current word from the LFSR random generator (shifts one bit per clk).
REQ-009 lfsr_load  out  1  active-high seed-load strobe to the random generator.
REQ-010 req  in  NUM_REQ  per-requester request, held high until granted.
REQ-011 grant  out  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-012 rand_out  out  OUT_W  random word, valid only in the cycle grant is non-zero.
REQ-013 ready  out  1  high while in READY state.

Function
REQ-014 States SHALL be WAIT_START, SEED, COOL, READY.
REQ-015 WAIT_START: start=1 at an edge -> SEED; req ignored.
REQ-016 SEED: lfsr_load=1 for exactly this one cycle; next edge -> COOL with cool counter loaded to COOL_CYCLES-1.
REQ-017 COOL: counter decrements each edge; at 0 -> READY; req ignored and not latched.
REQ-018 READY: if req!=0 at edge k, grant at cycle k+1 goes to the first set bit searching upward (wrapping) from pointer ptr; rand_out <= rand_in[OUT_W-1:0] at the same edge; state -> COOL with counter COOL_CYCLES-1.
REQ-019 READY with req==0: remain in READY, grant=0.
REQ-020 ptr SHALL update to (granted index + 1) mod NUM_REQ on each grant; unchanged otherwise.
REQ-021 Minimum grant spacing SHALL be COOL_CYCLES+1 cycles; throughput one grant per COOL_CYCLES+1 cycles under continuous request.
REQ-022 grant SHALL be zero in every cycle not immediately following a READY-state grant decision; never more than one bit set.
REQ-023 rand_out SHALL hold its last value between grants.
REQ-024 reseed=1 at any edge in COOL or READY -> SEED, overriding any grant decision in that edge (no grant issued); reseed in WAIT_START or SEED ignored.
REQ-025 start outside WAIT_START ignored.
REQ-026 A requester dropping req before being granted SHALL receive no grant; no request memory is kept.

Reset
REQ-027 rst low SHALL immediately force: state WAIT_START, lfsr_load 0, grant 0, rand_out 0, ready 0, ptr 0, cool counter 0.
REQ-028 Reset mid-operation (any state) SHALL abandon it; a new start is required before any grant.

Structure
REQ-029 Shared package rand_sched_pkg SHALL hold the state encoding and default NUM_REQ, OUT_W, COOL_CYCLES constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_picker (req, ptr -> one-hot pick, combinational); the FSM, counter, ptr and output registers stay in rand_scheduler.

Verification
REQ-031 Release rst, start=1 at cycle 3 -> lfsr_load high only in cycle 4, ready rises 16 cycles later, grant stays 0 throughout.
REQ-032 In READY, req=4'b0100 held -> grant=4'b0100 for exactly one cycle next cycle, rand_out equals rand_in[15:0] sampled at that edge; no further grant for 16 cycles.
REQ-033 req=4'b1111 held continuously -> grants 0001, 0010, 0100, 1000, 0001 spaced exactly 17 cycles apart.
REQ-034 reseed=1 in the same READY cycle as req=4'b0001 -> no grant, lfsr_load pulses one cycle, 16-cycle cooldown, then grant=0001.
REQ-035 rst low during COOL -> all outputs 0 immediately; after release, req held without start yields no grant for 100 cycles.
REQ-036 req[1] raised then dropped entirely within COOL -> no grant to requester 1; ptr unchanged.
